// File: rtl/reorder_logic_pkg.sv
// reorder_logic_pkg: shared helpers, FSM encodings and default parameters for the reorder sequencer
package reorder_logic_pkg;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    localparam int DEF_NUM_QUEUES     = 4;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_ORDER_DEPTH    = 8;
    localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/reorder_logic_order_fifo.sv
// reorder_logic_order_fifo: order FIFO holding the queue index of every issued request
// Ports:
//   clk_i, arst_n_i  clock, asynchronous active-low reset
//   clear_i          zero pointers and count at the next edge (overrides push/pop)
//   push_i, wdata_i  write an entry (ignored when full)
//   pop_i            retire the head entry (ignored when empty)
//   rdata_o          head entry
//   count_o          occupancy, full_o / empty_o status
module reorder_logic_order_fifo
    import reorder_logic_pkg::*;
#(
    parameter int  DEPTH     = DEF_ORDER_DEPTH,
    parameter int  WIDTH     = 2,
    localparam int CNT_WIDTH = clog2(DEPTH) + 1,
    localparam int PTR_WIDTH = CNT_WIDTH - 1
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic                 clear_i,
    input  logic                 push_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 pop_i,
    output logic [WIDTH-1:0]     rdata_o,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 full_o,
    output logic                 empty_o
);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [WIDTH-1:0]     mem_d [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 push_ok, pop_ok;

    assign full_o  = count_q == CNT_WIDTH'(DEPTH);
    assign empty_o = count_q == '0;
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointers are exactly log2(DEPTH) wide, so wrap is the natural overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
            count_d  = count_q + CNT_WIDTH'(push_ok) - CNT_WIDTH'(pop_ok);
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/reorder_logic_sequencer.sv
// reorder_logic_sequencer: restores issue order across NUM_QUEUES response queues
// Ports:
//   clk_i, arst_n_i                clock, asynchronous active-low reset
//   flush_i                        drop all outstanding order entries and the output register
//   issue_valid_i/ready_o/id_i     record the target queue of each issued request
//   status_i, data_i               per-queue head-valid and flattened head data
//   ack_o                          one-hot pop strobe to the queue at the order head
//   out_valid_o/ready_i/data_o/id_o  registered in-order output stage
//   count_o                        order FIFO occupancy
//   timeout_o                      sticky head-stall flag
// Optional feature: define REORDER_LOGIC_TIMEOUT_EN to drop a head entry whose queue
// stalls for TIMEOUT_CYCLES cycles; otherwise the head waits indefinitely.
module reorder_logic_sequencer
    import reorder_logic_pkg::*;
#(
    parameter int  NUM_QUEUES     = DEF_NUM_QUEUES,
    parameter int  DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int  ORDER_DEPTH    = DEF_ORDER_DEPTH,
    parameter int  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int SEL_WIDTH      = clog2(NUM_QUEUES),
    localparam int CNT_WIDTH      = clog2(ORDER_DEPTH) + 1
) (
    input  logic                             clk_i,
    input  logic                             arst_n_i,
    input  logic                             flush_i,
    input  logic                             issue_valid_i,
    output logic                             issue_ready_o,
    input  logic [SEL_WIDTH-1:0]             issue_id_i,
    input  logic [NUM_QUEUES-1:0]            status_i,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] data_i,
    output logic [NUM_QUEUES-1:0]            ack_o,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [DATA_WIDTH-1:0]            out_data_o,
    output logic [SEL_WIDTH-1:0]             out_id_o,
    output logic [CNT_WIDTH-1:0]             count_o,
    output logic                             timeout_o
);

    if ((1 << SEL_WIDTH) != NUM_QUEUES || NUM_QUEUES < 2) begin : g_bad_queues
        $error("NUM_QUEUES must be a power of two >= 2");
    end
    if ((1 << (CNT_WIDTH - 1)) != ORDER_DEPTH || ORDER_DEPTH < 2) begin : g_bad_depth
        $error("ORDER_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    state_e                state_q, state_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_WIDTH-1:0]  out_id_q, out_id_d;
    logic [SEL_WIDTH-1:0]  head;
    logic                  full, empty, run, slot_free, push, pop, drop;

    assign run           = state_q == ST_RUN;
    assign issue_ready_o = run & ~full;
    assign push          = issue_valid_i & issue_ready_o;
    assign slot_free     = ~out_valid_q | out_ready_i;
    assign pop           = run & ~flush_i & ~empty & slot_free & status_i[head];
    assign ack_o         = {NUM_QUEUES{pop}} & (NUM_QUEUES'(1) << head);

    reorder_logic_order_fifo #(
        .DEPTH (ORDER_DEPTH),
        .WIDTH (SEL_WIDTH)
    ) u_order_fifo (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .clear_i  (flush_i),
        .push_i   (push),
        .wdata_i  (issue_id_i),
        .pop_i    (pop | drop),
        .rdata_o  (head),
        .count_o  (count_o),
        .full_o   (full),
        .empty_o  (empty)
    );

`ifdef REORDER_LOGIC_TIMEOUT_EN
    localparam int STALL_WIDTH = clog2(TIMEOUT_CYCLES) + 1;
    logic [STALL_WIDTH-1:0] stall_q, stall_d;
    logic                   timeout_q, timeout_d;
    logic                   stalled;

    // Only cycles where the head could have been delivered count as stalls.
    assign stalled   = run & ~flush_i & ~empty & ~status_i[head] & slot_free;
    // The drop takes effect on the edge that completes the TIMEOUT_CYCLES-th stall cycle.
    assign drop      = stalled & (stall_q == STALL_WIDTH'(TIMEOUT_CYCLES - 1));
    assign timeout_o = timeout_q;

    always_comb begin
        stall_d   = (flush_i | pop | empty | drop) ? '0 : stalled ? stall_q + 1'b1 : stall_q;
        timeout_d = ~flush_i & (timeout_q | drop);
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign drop      = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d     = flush_i ? ST_FLUSH : ST_RUN;
        out_valid_d = flush_i ? 1'b0 : pop ? 1'b1 : out_ready_i ? 1'b0 : out_valid_q;
        out_data_d  = pop ? data_i[int'(head) * DATA_WIDTH +: DATA_WIDTH] : out_data_q;
        out_id_d    = pop ? head : out_id_q;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_id_o    = out_id_q;

endmodule

// File: tb/tb_reorder_logic_sequencer.sv
// tb_reorder_logic_sequencer: directed self-checking bench for reorder_logic_sequencer
module tb_reorder_logic_sequencer;

    localparam int NQ = 4;
    localparam int DW = 32;
    localparam int OD = 8;
    localparam int TC = 4;
    localparam int SW = 2;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            arst_n = 1'b0;
    logic            flush = 1'b0;
    logic            issue_valid = 1'b0;
    logic            issue_ready;
    logic [SW-1:0]   issue_id = '0;
    logic [NQ-1:0]   status = '0;
    logic [NQ*DW-1:0] data = '0;
    logic [NQ-1:0]   ack;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_id;
    logic [CW-1:0]   count;
    logic            timeout;
    int              total = 0;
    int              bad = 0;

    reorder_logic_sequencer #(
        .NUM_QUEUES     (NQ),
        .DATA_WIDTH     (DW),
        .ORDER_DEPTH    (OD),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk_i         (clk),
        .arst_n_i      (arst_n),
        .flush_i       (flush),
        .issue_valid_i (issue_valid),
        .issue_ready_o (issue_ready),
        .issue_id_i    (issue_id),
        .status_i      (status),
        .data_i        (data),
        .ack_o         (ack),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_data_o    (out_data),
        .out_id_o      (out_id),
        .count_o       (count),
        .timeout_o     (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] val(input int q, input int tag);
        return {16'hA5A5, 8'(tag), 8'(q)};
    endfunction

    task automatic set_data(input int tag);
        for (int q = 0; q < NQ; q++) data[q*DW +: DW] = val(q, tag);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int id);
        issue_valid = 1'b1;
        issue_id = SW'(id);
        step();
        issue_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL rst_issue_ready got=%b exp=1", issue_ready); end
        total++; if (ack !== 4'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0000", ack); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        total++; if (out_id !== 2'd0) begin bad++; $display("FAIL rst_out_id got=%0d exp=0", out_id); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b exp=0", timeout); end
        #1 arst_n = 1'b1;
    endtask

    task automatic test_in_order();
        int ids[4] = '{2, 0, 3, 1};
        logic [NQ-1:0] st[4] = '{4'b0000, 4'b0010, 4'b1010, 4'b1011};
        logic [NQ-1:0] e;
        step();
        out_ready = 1'b1;
        set_data(1);
        for (int i = 0; i < 4; i++) begin
            issue_valid = 1'b1;
            issue_id = SW'(ids[i]);
            status = st[i];
            #1;
            total++; if (ack !== 4'b0) begin bad++; $display("FAIL order_wait_ack[%0d] got=%b exp=0000", i, ack); end
            step();
        end
        issue_valid = 1'b0;
        status = 4'b1111;
        total++; if (count !== 4'd4) begin bad++; $display("FAIL order_count got=%0d exp=4", count); end
        for (int k = 0; k < 4; k++) begin
            #1;
            e = 4'b0001 << ids[k];
            total++; if (ack !== e) begin bad++; $display("FAIL order_ack[%0d] got=%b exp=%b", k, ack, e); end
            step();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL order_valid[%0d] got=%b exp=1", k, out_valid); end
            total++; if (out_id !== SW'(ids[k])) begin bad++; $display("FAIL order_id[%0d] got=%0d exp=%0d", k, out_id, ids[k]); end
            total++; if (out_data !== val(ids[k], 1)) begin bad++; $display("FAIL order_data[%0d] got=%h exp=%h", k, out_data, val(ids[k], 1)); end
        end
        #1;
        total++; if (ack !== 4'b0) begin bad++; $display("FAIL order_empty_ack got=%b exp=0000", ack); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL order_end_count got=%0d exp=0", count); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL order_valid_drop got=%b exp=0", out_valid); end
        status = '0;
    endtask

    task automatic test_full_back_to_back();
        out_ready = 1'b0;
        status = 4'b0001;
        set_data(2);
        for (int i = 0; i < 9; i++) issue(i % 4);
        #1;
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", issue_ready); end
        total++; if (count !== 4'd8) begin bad++; $display("FAIL full_count got=%0d exp=8", count); end
        out_ready = 1'b1;
        status = 4'b0010;
        issue_valid = 1'b1;
        issue_id = 2'd3;
        #1;
        total++; if (ack !== 4'b0010) begin bad++; $display("FAIL full_pop_ack got=%b exp=0010", ack); end
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL full_pop_ready got=%b exp=0", issue_ready); end
        step();
        issue_valid = 1'b0;
        status = '0;
        #1;
        total++; if (count !== 4'd7) begin bad++; $display("FAIL full_after_count got=%0d exp=7", count); end
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL full_after_ready got=%b exp=1", issue_ready); end
        total++; if (out_id !== 2'd1) begin bad++; $display("FAIL full_after_id got=%0d exp=1", out_id); end
        status = 4'b1111;
        for (int n = 0; n < 20 && count != 0; n++) step();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL full_drain_count got=%0d exp=0", count); end
        status = '0;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_drain_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        issue(1);
        issue(2);
        set_data(3);
        status = 4'b0110;
        #1;
        total++; if (ack !== 4'b0010) begin bad++; $display("FAIL bp_first_ack got=%b exp=0010", ack); end
        step();
        set_data(4);
        #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", out_valid); end
        total++; if (out_id !== 2'd1) begin bad++; $display("FAIL bp_id got=%0d exp=1", out_id); end
        for (int i = 0; i < 3; i++) begin
            total++; if (ack !== 4'b0) begin bad++; $display("FAIL bp_hold_ack[%0d] got=%b exp=0000", i, ack); end
            total++; if (out_data !== val(1, 3)) begin bad++; $display("FAIL bp_hold_data[%0d] got=%h exp=%h", i, out_data, val(1, 3)); end
            step();
        end
        out_ready = 1'b1;
        #1;
        total++; if (ack !== 4'b0100) begin bad++; $display("FAIL bp_second_ack got=%b exp=0100", ack); end
        step();
        total++; if (out_id !== 2'd2) begin bad++; $display("FAIL bp_second_id got=%0d exp=2", out_id); end
        total++; if (out_data !== val(2, 4)) begin bad++; $display("FAIL bp_second_data got=%h exp=%h", out_data, val(2, 4)); end
        status = '0;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_end_valid got=%b exp=0", out_valid); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL bp_end_count got=%0d exp=0", count); end
    endtask

    task automatic test_wrap();
        logic [NQ-1:0] e;
        logic [CW-1:0] ec;
        out_ready = 1'b1;
        status = 4'b1111;
        for (int c = 0; c <= 20; c++) begin
            issue_valid = c < 20;
            issue_id = SW'(c % 4);
            set_data(c);
            #1;
            e = (c == 0) ? 4'b0 : 4'b0001 << ((c - 1) % 4);
            ec = (c == 0) ? 4'd0 : 4'd1;
            total++; if (ack !== e) begin bad++; $display("FAIL wrap_ack[%0d] got=%b exp=%b", c, ack, e); end
            total++; if (count !== ec) begin bad++; $display("FAIL wrap_count[%0d] got=%0d exp=%0d", c, count, ec); end
            step();
            if (c > 0) begin
                total++; if (out_id !== SW'((c - 1) % 4)) begin bad++; $display("FAIL wrap_id[%0d] got=%0d exp=%0d", c, out_id, (c - 1) % 4); end
                total++; if (out_data !== val((c - 1) % 4, c)) begin bad++; $display("FAIL wrap_data[%0d] got=%h exp=%h", c, out_data, val((c - 1) % 4, c)); end
            end
        end
        issue_valid = 1'b0;
        status = '0;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL wrap_end_count got=%0d exp=0", count); end
        step();
    endtask

    task automatic test_timeout();
        out_ready = 1'b1;
        status = 4'b1000;
        set_data(5);
        issue(2);
        issue(3);
`ifdef REORDER_LOGIC_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (ack !== 4'b0) begin bad++; $display("FAIL to_stall_ack[%0d] got=%b exp=0000", i, ack); end
            total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_stall_flag[%0d] got=%b exp=0", i, timeout); end
            step();
        end
        #1;
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_flag got=%b exp=1", timeout); end
        total++; if (count !== 4'd1) begin bad++; $display("FAIL to_count got=%0d exp=1", count); end
        total++; if (ack !== 4'b1000) begin bad++; $display("FAIL to_next_ack got=%b exp=1000", ack); end
        step();
`else
        for (int i = 0; i < 6; i++) begin
            #1;
            total++; if (ack !== 4'b0) begin bad++; $display("FAIL wait_ack[%0d] got=%b exp=0000", i, ack); end
            total++; if (timeout !== 1'b0) begin bad++; $display("FAIL wait_flag[%0d] got=%b exp=0", i, timeout); end
            total++; if (count !== 4'd2) begin bad++; $display("FAIL wait_count[%0d] got=%0d exp=2", i, count); end
            step();
        end
        status = 4'b1100;
        #1;
        total++; if (ack !== 4'b0100) begin bad++; $display("FAIL wait_head_ack got=%b exp=0100", ack); end
        step();
        #1;
        total++; if (ack !== 4'b1000) begin bad++; $display("FAIL wait_next_ack got=%b exp=1000", ack); end
        step();
`endif
        total++; if (out_id !== 2'd3) begin bad++; $display("FAIL to_out_id got=%0d exp=3", out_id); end
        total++; if (out_data !== val(3, 5)) begin bad++; $display("FAIL to_out_data got=%h exp=%h", out_data, val(3, 5)); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL to_end_count got=%0d exp=0", count); end
        status = '0;
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        status = 4'b0001;
        for (int i = 0; i < 6; i++) issue(i % 4);
        status = '0;
        #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fl_pre_valid got=%b exp=1", out_valid); end
        total++; if (count !== 4'd5) begin bad++; $display("FAIL fl_pre_count got=%0d exp=5", count); end
        flush = 1'b1;
        out_ready = 1'b1;
        status = 4'b1111;
        #1;
        total++; if (ack !== 4'b0) begin bad++; $display("FAIL fl_ack got=%b exp=0000", ack); end
        step();
        flush = 1'b0;
        #1;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL fl_count got=%0d exp=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%b exp=0", out_valid); end
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL fl_ready_low got=%b exp=0", issue_ready); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL fl_timeout got=%b exp=0", timeout); end
        total++; if (ack !== 4'b0) begin bad++; $display("FAIL fl_state_ack got=%b exp=0000", ack); end
        step();
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL fl_ready_back got=%b exp=1", issue_ready); end
        status = '0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        set_data(6);
        issue(1);
        status = 4'b0010;
        step();
        status = '0;
        issue(2);
        #1;
        total++; if (out_valid !== 1'b1 || count !== 4'd1) begin bad++; $display("FAIL mid_pre got=%b/%0d exp=1/1", out_valid, count); end
        #2 arst_n = 1'b0;
        #1;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL mid_data got=%h exp=0", out_data); end
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", issue_ready); end
        #1 arst_n = 1'b1;
        out_ready = 1'b1;
        step();
    endtask

    initial begin
        set_data(0);
        test_reset();
        test_in_order();
        test_full_back_to_back();
        test_backpressure();
        test_wrap();
        test_timeout();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
